// File: rtl/alu_issue_unit_if.sv
// Request, response and ALU operand/result signals of the ALU issue unit.
// The issue unit is the initiator towards the ALU, so it uses the master modport.
interface alu_issue_unit_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_mode;
  logic [2:0]    req_a;
  logic [2:0]    req_b;
  logic          req_cin;

  logic          alu_m0;
  logic          alu_m1;
  logic [2:0]    alu_a;
  logic [2:0]    alu_b;
  logic          alu_cin;
  logic          alu_cout;
  logic [2:0]    alu_out;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_result;
  logic [1:0]    rsp_mode;
  logic [CW-1:0] fifo_count;

  modport master (
    input  req_valid, req_mode, req_a, req_b, req_cin,
    output req_ready,
    output alu_m0, alu_m1, alu_a, alu_b, alu_cin,
    input  alu_cout, alu_out,
    output rsp_valid, rsp_result, rsp_mode, fifo_count,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_mode, req_a, req_b, req_cin,
    input  req_ready,
    input  alu_m0, alu_m1, alu_a, alu_b, alu_cin,
    output alu_cout, alu_out,
    input  rsp_valid, rsp_result, rsp_mode, fifo_count,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Queues ALU requests in a FIFO, drives them one at a time into the combinational
// ALU and holds each captured result in a valid/ready response register.
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  op_t           fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  op_t           op_q, op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [3:0]    rsp_result_q, rsp_result_d;
  logic [1:0]    rsp_mode_q, rsp_mode_d;

  logic          req_ready;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  op_t           req_op;
  op_t           head_op;

  // The full check uses the registered count, so a pop in the same cycle never frees a slot early.
  assign req_ready     = rst_n && (count_q < CW'(DEPTH));
  assign push          = bus.req_valid && req_ready;
  assign fifo_nonempty = (count_q != '0);
  assign req_op        = '{mode: bus.req_mode, a: bus.req_a, b: bus.req_b, cin: bus.req_cin};
  assign head_op       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_mode_d   = rsp_mode_q;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          op_d    = head_op;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        rsp_result_d = {bus.alu_cout, bus.alu_out};
        rsp_mode_d   = op_q.mode;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            op_d    = head_op;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_mode_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_mode_q   <= rsp_mode_d;
    end
  end

  // Storage needs no reset: the pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= req_op;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_m1     = op_q.mode[1];
  assign bus.alu_m0     = op_q.mode[0];
  assign bus.alu_a      = op_q.a;
  assign bus.alu_b      = op_q.b;
  assign bus.alu_cin    = op_q.cin;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_mode   = rsp_mode_q;
  assign bus.fifo_count = count_q;

  count_bounded_a : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));

  rsp_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !bus.rsp_ready) |=>
      (rsp_valid_q && $stable(rsp_result_q) && $stable(rsp_mode_q)));

  pop_nonempty_a : assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> fifo_nonempty);
endmodule
